// File: rtl/datapath_fifo_arbiter.sv
// Two-requester round-robin packer into a 128-to-192 FIFO, with a paced
// single-word read-out stage that presents each 192-bit word on an m_valid/m_ready stream.
module datapath_fifo_arbiter #(
  parameter int RD_GAP = 30,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s0_valid,
  input  logic [127:0]       s0_data,
  output logic               s0_ready,
  input  logic               s1_valid,
  input  logic [127:0]       s1_data,
  output logic               s1_ready,
  output logic               fifo_wr,
  output logic [127:0]       fifo_din,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  input  logic               fifo_threshold,
  output logic               fifo_rd,
  input  logic [191:0]       fifo_dout,
  output logic               m_valid,
  output logic [191:0]       m_data,
  input  logic               m_ready,
  output logic [1:0]         grant,
  output logic [CNT_W-1:0]   words_written,
  output logic               err_drop
);

  localparam logic [0:0] W_IDLE   = 1'b0;
  localparam logic [0:0] W_BEAT_B = 1'b1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_HOLD  = 2'd2;

  logic [0:0] w_state_r;
  logic       owner_r;
  logic       pri_r;
  logic [1:0] r_state_r;
  logic [5:0] gap_cnt_r;

  logic       sel_s;
  logic       cur_s;
  logic       can_grant_s;
  logic       active_s;
  logic       cur_valid_s;

  // Round-robin choice among valid requesters; pri_r=1 favours requester 1.
  always_comb begin
    sel_s = 1'b0;
    if (s0_valid && s1_valid) begin
      sel_s = pri_r;
    end else begin
      sel_s = s1_valid;
    end
  end

  // Ownership: new owner only from idle with room in the FIFO, locked owner during beat B.
  always_comb begin
    can_grant_s = (w_state_r == W_IDLE) && !fifo_threshold && !fifo_full &&
                  (s0_valid || s1_valid);
    cur_s       = 1'b0;
    if (w_state_r == W_BEAT_B) begin
      cur_s = owner_r;
    end else begin
      cur_s = sel_s;
    end
    active_s    = !rst && ((w_state_r == W_BEAT_B) || can_grant_s);
    cur_valid_s = cur_s ? s1_valid : s0_valid;
  end

  // Handshake outputs follow the current owner; gated by rst so reset is immediate.
  always_comb begin
    grant = 2'b00;
    if (active_s) begin
      grant = cur_s ? 2'b10 : 2'b01;
    end else begin
      grant = 2'b00;
    end
    s0_ready = grant[0];
    s1_ready = grant[1];
    fifo_wr  = active_s && cur_valid_s;
    fifo_din = cur_s ? s1_data : s0_data;
  end

  // Write FSM, pair counter, round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_r     <= W_IDLE;
      owner_r       <= 1'b0;
      pri_r         <= 1'b0;
      words_written <= '0;
      err_drop      <= 1'b0;
    end else begin
      if (fifo_wr && fifo_full) begin
        err_drop <= 1'b1;
      end
      case (w_state_r)
        W_IDLE: begin
          if (fifo_wr) begin
            owner_r   <= cur_s;
            w_state_r <= W_BEAT_B;
          end
        end
        W_BEAT_B: begin
          if (fifo_wr) begin
            words_written <= words_written + CNT_W'(1);
            pri_r         <= ~owner_r;
            w_state_r     <= W_IDLE;
          end
        end
        default: w_state_r <= W_IDLE;
      endcase
    end
  end

  // Read strobe is combinational so fifo_dout lands in R_FETCH, giving m_valid two cycles later.
  always_comb begin
    fifo_rd = !rst && (r_state_r == R_IDLE) && !fifo_empty && (gap_cnt_r == 6'd0);
  end

  // Read FSM with inter-read gap counter and single-word output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_r <= R_IDLE;
      gap_cnt_r <= 6'd0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      if (fifo_rd) begin
        gap_cnt_r <= 6'(RD_GAP - 1);
      end else if (gap_cnt_r != 6'd0) begin
        gap_cnt_r <= gap_cnt_r - 6'd1;
      end
      case (r_state_r)
        R_IDLE: begin
          if (fifo_rd) begin
            r_state_r <= R_FETCH;
          end
        end
        R_FETCH: begin
          m_data    <= fifo_dout;
          m_valid   <= 1'b1;
          r_state_r <= R_HOLD;
        end
        R_HOLD: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            r_state_r <= R_IDLE;
          end
        end
        default: r_state_r <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_fifo_arbiter.sv
// Directed bench for datapath_fifo_arbiter with a small behavioural 128-to-192 FIFO model.
module tb_datapath_fifo_arbiter;

  localparam int RD_GAP = 30;
  localparam int CNT_W  = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               s0_valid = 1'b0, s1_valid = 1'b0;
  logic [127:0]       s0_data = '0, s1_data = '0;
  logic               s0_ready, s1_ready;
  logic               fifo_wr, fifo_rd;
  logic [127:0]       fifo_din;
  logic               fifo_full, fifo_empty, fifo_threshold;
  logic [191:0]       fifo_dout;
  logic               m_valid;
  logic [191:0]       m_data;
  logic               m_ready = 1'b0;
  logic [1:0]         grant;
  logic [CNT_W-1:0]   words_written;
  logic               err_drop;

  logic               thr = 1'b0;
  logic               force_full = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  datapath_fifo_arbiter #(.RD_GAP(RD_GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold),
    .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .grant(grant), .words_written(words_written), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  // FIFO model: first beat staged, second beat's low 64 bits placed on top.
  logic [191:0] mem [0:15];
  logic [3:0]   wptr, rptr;
  logic [4:0]   cnt;
  logic         half;
  logic [127:0] stage;

  assign fifo_empty     = (cnt == 5'd0);
  assign fifo_full      = force_full || (cnt == 5'd16);
  assign fifo_threshold = thr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0; rptr <= '0; cnt <= '0; half <= 1'b0; stage <= '0; fifo_dout <= '0;
    end else begin
      if (fifo_wr) begin
        if (!half) begin
          stage <= fifo_din;
          half  <= 1'b1;
        end else begin
          mem[wptr] <= {fifo_din[63:0], stage};
          wptr      <= wptr + 4'd1;
          half      <= 1'b0;
        end
      end
      if (fifo_rd) begin
        fifo_dout <= mem[rptr];
        rptr      <= rptr + 4'd1;
      end
      cnt <= cnt + 5'(fifo_wr && half) - 5'(fifo_rd);
    end
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1; thr = 1'b0; force_full = 1'b0;
    #2;
    check("rst_grant", 192'(grant), 192'd0);
    check("rst_s0_ready", 192'(s0_ready), 192'd0);
    check("rst_s1_ready", 192'(s1_ready), 192'd0);
    check("rst_fifo_wr", 192'(fifo_wr), 192'd0);
    check("rst_fifo_rd", 192'(fifo_rd), 192'd0);
    check("rst_m_valid", 192'(m_valid), 192'd0);
    check("rst_m_data", m_data, 192'd0);
    check("rst_words", 192'(words_written), 192'd0);
    check("rst_err_drop", 192'(err_drop), 192'd0);
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_pair(input logic [127:0] a, input logic [127:0] b);
    s0_valid = 1'b1; s0_data = a;
    @(posedge clk); #1;
    s0_data = b;
    @(posedge clk); #1;
    s0_valid = 1'b0;
  endtask

  logic [127:0] a_word;
  logic [191:0] held;
  int rd_t [0:3];
  int mv_t [0:3];
  int n_rd, n_mv, rd_seen, changes;
  logic prev_mv, got_mv;

  initial begin
    a_word = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    // Single pair from s0, then read-out with latency 2.
    do_reset();
    s0_valid = 1'b1; s0_data = a_word;
    @(negedge clk);
    check("pair_a_ready", 192'(s0_ready), 192'd1);
    check("pair_a_wr", 192'(fifo_wr), 192'd1);
    check("pair_a_grant", 192'(grant), 192'd1);
    check("pair_a_din", 192'(fifo_din), 192'(a_word));
    @(posedge clk); #1;
    s0_data = 128'hB;
    @(negedge clk);
    check("pair_b_grant", 192'(grant), 192'd1);
    check("pair_b_wr", 192'(fifo_wr), 192'd1);
    check("pair_b_s1_ready", 192'(s1_ready), 192'd0);
    @(posedge clk); #1;
    s0_valid = 1'b0;
    @(negedge clk);
    check("pair_words", 192'(words_written), 192'd1);
    check("pair_idle_grant", 192'(grant), 192'd0);
    check("pair_rd", 192'(fifo_rd), 192'd1);
    @(negedge clk);
    check("pair_fetch_mv", 192'(m_valid), 192'd0);
    @(negedge clk);
    check("pair_mv", 192'(m_valid), 192'd1);
    check("pair_m_data", m_data, {64'hB, a_word});
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("pair_mv_drop", 192'(m_valid), 192'd0);

    // Contention: both requesters valid for four pairs.
    do_reset();
    s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 128'hA0; s1_data = 128'hA1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("cont_grant", 192'(grant), ((i / 2) % 2 == 1) ? 192'd2 : 192'd1);
      check("cont_wr", 192'(fifo_wr), 192'd1);
      check("cont_din", 192'(fifo_din), ((i / 2) % 2 == 1) ? 192'hA1 : 192'hA0);
      @(posedge clk); #1;
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    check("cont_words", 192'(words_written), 192'd4);

    // Threshold blocks new ownership but not beat B.
    do_reset();
    thr = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1;
    @(negedge clk);
    check("thr_s0_ready", 192'(s0_ready), 192'd0);
    check("thr_s1_ready", 192'(s1_ready), 192'd0);
    check("thr_wr", 192'(fifo_wr), 192'd0);
    @(posedge clk); #1;
    thr = 1'b0;
    @(negedge clk);
    check("thr_clear_ready", 192'(s0_ready), 192'd1);
    @(posedge clk); #1;
    thr = 1'b1;
    @(negedge clk);
    check("thr_b_ready", 192'(s0_ready), 192'd1);
    check("thr_b_wr", 192'(fifo_wr), 192'd1);
    check("thr_b_s1_ready", 192'(s1_ready), 192'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("thr_words", 192'(words_written), 192'd1);
    check("thr_idle_s1", 192'(s1_ready), 192'd0);
    check("thr_idle_s0", 192'(s0_ready), 192'd0);
    s0_valid = 1'b0; s1_valid = 1'b0; thr = 1'b0;

    // Read pacing: three words, m_ready held high.
    do_reset();
    m_ready = 1'b1; s0_valid = 1'b1;
    n_rd = 0; n_mv = 0; prev_mv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_t[k] = -1000; mv_t[k] = -1000;
    end
    for (int k = 0; k < 120; k++) begin
      s0_data = 128'(k);
      @(negedge clk);
      if (fifo_rd && n_rd < 4) begin rd_t[n_rd] = k; n_rd++; end
      if (m_valid && !prev_mv && n_mv < 4) begin mv_t[n_mv] = k; n_mv++; end
      prev_mv = m_valid;
      @(posedge clk); #1;
      if (k == 5) s0_valid = 1'b0;
    end
    check("pace_n_rd", 192'(n_rd), 192'd3);
    check("pace_gap1", 192'(rd_t[1] - rd_t[0]), 192'(RD_GAP));
    check("pace_gap2", 192'(rd_t[2] - rd_t[1]), 192'(RD_GAP));
    for (int k = 0; k < 3; k++) begin
      check("pace_mv_lat", 192'(mv_t[k] - rd_t[k]), 192'd2);
    end
    m_ready = 1'b0;

    // Backpressure: output word must hold with no further reads.
    do_reset();
    push_pair(128'hC0C0, 128'hD0D0);
    push_pair(128'hC1C1, 128'hD1D1);
    got_mv = 1'b0;
    for (int k = 0; k < 20 && !got_mv; k++) begin
      @(negedge clk);
      got_mv = m_valid;
    end
    check("bp_mv_wait", 192'(got_mv), 192'd1);
    check("bp_first_word", m_data, {64'hD0D0, 128'hC0C0});
    held = m_data; rd_seen = 0; changes = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fifo_rd) rd_seen++;
      if (m_data !== held) changes++;
    end
    check("bp_no_rd", 192'(rd_seen), 192'd0);
    check("bp_stable", 192'(changes), 192'd0);
    check("bp_mv_held", 192'(m_valid), 192'd1);

    // Overflow: FIFO reports full while beat B is written.
    do_reset();
    s0_valid = 1'b1; s0_data = 128'hE0;
    @(posedge clk); #1;
    force_full = 1'b1; s0_data = 128'hE1;
    @(negedge clk);
    check("err_b_wr", 192'(fifo_wr), 192'd1);
    @(posedge clk); #1;
    force_full = 1'b0; s0_valid = 1'b0;
    @(negedge clk);
    check("err_set", 192'(err_drop), 192'd1);
    repeat (5) @(negedge clk);
    check("err_sticky", 192'(err_drop), 192'd1);
    do_reset();
    @(negedge clk);
    check("err_cleared", 192'(err_drop), 192'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/datapath_fifo_arbiter.md
DATAPATH_FIFO_ARBITER -- requirements
Module: datapath_fifo_arbiter

Interface
REQ-001 SHALL have parameter RD_GAP, default 30: minimum clock cycles between successive fifo_rd pulses (legal range 2..63).
REQ-002 SHALL have parameter CNT_W, default 16: width of the words_written counter.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s0_valid / s0_data / s0_ready  in/in/out  1/128/1  requester 0 beat stream.
REQ-006 s1_valid / s1_data / s1_ready  in/in/out  1/128/1  requester 1 beat stream.
REQ-007 fifo_wr / fifo_din  out/out  1/128  write strobe and beat to the 128-to-192 FIFO.
REQ-008 fifo_full / fifo_empty / fifo_threshold  input  1 each  FIFO status flags, combinational from the FIFO.
REQ-009 fifo_rd / fifo_dout  out/in  1/192  read strobe; fifo_dout is valid the cycle after fifo_rd. The FIFO SHALL be instantiated with its CLK_DIV set to 1.
REQ-010 m_valid / m_data / m_ready  out/out/in  1/192/1  output word stream.
REQ-011 grant  output  2  one-hot owner of the current pair; 2'b00 when no owner.
REQ-012 words_written  output  CNT_W  count of completed pairs; wraps modulo 2^CNT_W.
REQ-013 err_drop  output  1  sticky; set when fifo_wr and fifo_full are both high.

Function
REQ-014 A transfer SHALL be one pair of beats: beat A (128 b, first) then beat B (low 64 b used, second), both from the same requester.
REQ-015 Write FSM states SHALL be W_IDLE and W_BEAT_B.
REQ-016 In W_IDLE, ownership SHALL be granted only when fifo_threshold=0 and fifo_full=0.
REQ-017 In W_IDLE, the grant SHALL be round-robin between valid requesters; the last owner has lowest priority; requester 0 wins the first contention after reset.
REQ-018 In W_IDLE, s_ready of the chosen requester SHALL be high combinationally in the same cycle; s_valid&s_ready SHALL assert fifo_wr with fifo_din=s_data and move to W_BEAT_B.
REQ-019 In W_BEAT_B, grant SHALL stay locked to the owner, and only the owner's s_ready SHALL be high, independent of fifo flags.
REQ-020 In W_BEAT_B, the handshake SHALL write beat B, increment words_written, update the round-robin pointer and return to W_IDLE.
REQ-021 In W_BEAT_B, the owner may stall indefinitely; no other requester is served meanwhile.
REQ-022 At most one fifo_wr per cycle; the non-granted s_ready SHALL always be 0.
REQ-023 Read FSM states SHALL be R_IDLE, R_FETCH, R_HOLD, plus gap counter gap_cnt (6 b).
REQ-024 gap_cnt SHALL load RD_GAP-1 on each fifo_rd and count down to 0 every cycle it is nonzero.
REQ-025 In R_IDLE with fifo_empty=0 and gap_cnt=0, fifo_rd SHALL pulse for one cycle and the FSM SHALL move to R_FETCH.
REQ-026 R_FETCH SHALL capture fifo_dout into m_data, set m_valid and move to R_HOLD; latency from fifo_rd to m_valid is 2 cycles.
REQ-027 In R_HOLD, m_data and m_valid SHALL stay stable until m_ready; on m_valid&m_ready the FSM SHALL return to R_IDLE.
REQ-028 In R_HOLD, no further fifo_rd SHALL be issued (single-word output buffer).
REQ-029 Write and read FSMs SHALL run concurrently; simultaneous fifo_wr and fifo_rd is legal.
REQ-030 err_drop SHALL set on fifo_wr&fifo_full and clear only on rst.

Reset
REQ-031 On rst high, asynchronously: both FSMs idle, grant=0, s0_ready=s1_ready=0, fifo_wr=0, fifo_rd=0, m_valid=0, m_data=0, words_written=0, err_drop=0, gap_cnt=0, round-robin pointer favouring requester 0.
REQ-032 Reset asserted mid-pair SHALL abandon the pair; the FIFO is reset in the same domain by the integrator.
REQ-033 After rst falls, the first grant SHALL be possible on the first rising edge.

Verification
REQ-034 Single pair: s0 sends A=128'h1..., B=64'hB; expect fifo_wr twice, grant=01 across both beats, words_written=1; after RD_GAP and read, m_data={B, A[127:64], A[63:0]}.
REQ-035 Contention: s0 and s1 both valid continuously for 4 pairs; expect grant order 01,10,01,10 and beats never interleaved.
REQ-036 Threshold: fifo_threshold=1 in W_IDLE; expect s0_ready=s1_ready=0. With threshold=1 set during W_BEAT_B, beat B is still accepted.
REQ-037 Read pacing: FIFO holds 3 words, m_ready=1; expect fifo_rd pulses exactly RD_GAP cycles apart and m_valid 2 cycles after each pulse.
REQ-038 Backpressure: m_ready=0 for 100 cycles; expect m_data stable and no fifo_rd. Force fifo_full during fifo_wr; expect err_drop=1 until rst.
